// File: rtl/interval_hist_reader_pkg.sv
// Shared pipeline package: histogram geometry and the reader FSM state type.
package interval_hist_reader_pkg;
  localparam int INTERVAL_SIZE = 8;
  localparam int PARA          = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/interval_hist_reader.sv
// Histogram reader: snapshots per-bin counters on start, streams every bin out
// over a valid/ready handshake, and reports the argmax bin (lowest index wins
// ties) with a one-cycle done pulse.
module interval_hist_reader
  import interval_hist_reader_pkg::*;
#(
  parameter int interval_size = INTERVAL_SIZE,
  parameter int para          = PARA
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start_i,
  input  logic [interval_size-1:0][para-1:0]    interval_cnt_i,
  output logic                                  busy_o,
  output logic                                  bin_valid_o,
  input  logic                                  bin_ready_i,
  output logic [$clog2(interval_size)-1:0]      bin_idx_o,
  output logic [para-1:0]                       bin_cnt_o,
  output logic [interval_size-1:0]              mode_o,
  output logic [para-1:0]                       max_cnt_o,
  output logic                                  done_o
);

  localparam int IW = $clog2(interval_size);

  state_e                             state_q, state_d;
  logic [interval_size-1:0][para-1:0] snap_q, snap_d;
  logic [IW-1:0]                      idx_q, idx_d;
  logic [para-1:0]                    run_max_q, run_max_d;
  logic [interval_size-1:0]           run_mode_q, run_mode_d;
  logic [para-1:0]                    max_cnt_q, max_cnt_d;
  logic [interval_size-1:0]           mode_q, mode_d;

  logic                               hs, last, gt;
  logic [para-1:0]                    cur_cnt;
  logic [interval_size-1:0]           cur_oh;

  assign cur_cnt = snap_q[idx_q];
  assign hs      = (state_q == ST_SCAN) && bin_ready_i;
  assign last    = (idx_q == IW'(interval_size - 1));
  // Strictly greater: an equal later bin never displaces an earlier one.
  assign gt      = (cur_cnt > run_max_q);
  assign cur_oh  = {{(interval_size-1){1'b0}}, 1'b1} << idx_q;

  // Next-state, snapshot capture and running argmax.
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    run_max_d  = run_max_q;
    run_mode_d = run_mode_q;
    max_cnt_d  = max_cnt_q;
    mode_d     = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          snap_d     = interval_cnt_i;
          idx_d      = '0;
          run_max_d  = '0;
          run_mode_d = '0;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (hs) begin
          if (gt) begin
            run_max_d  = cur_cnt;
            run_mode_d = cur_oh;
          end
          if (last) begin
            // Publish the result so it is already valid while done_o is high.
            max_cnt_d = run_max_d;
            mode_d    = run_mode_d;
            idx_d     = '0;
            state_d   = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset abandons any scan and clears the published result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      snap_q     <= '0;
      idx_q      <= '0;
      run_max_q  <= '0;
      run_mode_q <= '0;
      max_cnt_q  <= '0;
      mode_q     <= '0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      run_max_q  <= run_max_d;
      run_mode_q <= run_mode_d;
      max_cnt_q  <= max_cnt_d;
      mode_q     <= mode_d;
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign bin_valid_o = (state_q == ST_SCAN);
  assign done_o      = (state_q == ST_DONE);
  assign bin_idx_o   = idx_q;
  assign bin_cnt_o   = bin_valid_o ? cur_cnt : '0;
  assign mode_o      = mode_q;
  assign max_cnt_o   = max_cnt_q;

endmodule

// File: tb/tb_interval_hist_reader.sv
// Bench for interval_hist_reader: directed scans, a per-cycle model compare,
// and literal expectations for latency and argmax results.
module tb_interval_hist_reader;
  localparam int N = 8;
  localparam int P = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start_i = 1'b0;
  logic [N-1:0][P-1:0] interval_cnt_i = '0;
  logic               busy_o, bin_valid_o, bin_ready_i, done_o;
  logic [2:0]         bin_idx_o;
  logic [P-1:0]       bin_cnt_o, max_cnt_o;
  logic [N-1:0]       mode_o;

  int total = 0;
  int bad   = 0;

  interval_hist_reader #(.interval_size(N), .para(P)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .interval_cnt_i(interval_cnt_i),
    .busy_o(busy_o), .bin_valid_o(bin_valid_o), .bin_ready_i(bin_ready_i),
    .bin_idx_o(bin_idx_o), .bin_cnt_o(bin_cnt_o), .mode_o(mode_o),
    .max_cnt_o(max_cnt_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 streaming bins, 2 result cycle.
  int          m_phase;
  int          m_idx;
  logic [P-1:0] m_snap [N];
  logic [P-1:0] m_max;
  logic [N-1:0] m_mode;

  function automatic logic [P-1:0] f_max(input logic [P-1:0] s [N]);
    logic [P-1:0] b = '0;
    for (int i = 0; i < N; i++) if (s[i] > b) b = s[i];
    return b;
  endfunction

  function automatic logic [N-1:0] f_mode(input logic [P-1:0] s [N]);
    logic [P-1:0] b = '0;
    logic [N-1:0] m = '0;
    for (int i = 0; i < N; i++)
      if (s[i] > b) begin b = s[i]; m = '0; m[i] = 1'b1; end
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_idx <= 0; m_max <= '0; m_mode <= '0;
      for (int i = 0; i < N; i++) m_snap[i] <= '0;
    end else begin
      case (m_phase)
        0: if (start_i) begin
             for (int i = 0; i < N; i++) m_snap[i] <= interval_cnt_i[i];
             m_idx <= 0; m_phase <= 1;
           end
        1: if (bin_ready_i) begin
             if (m_idx == N - 1) begin
               m_phase <= 2; m_max <= f_max(m_snap); m_mode <= f_mode(m_snap);
             end else m_idx <= m_idx + 1;
           end
        default: m_phase <= 0;
      endcase
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy",  32'(busy_o),      32'(m_phase != 0));
      check("valid", 32'(bin_valid_o), 32'(m_phase == 1));
      check("done",  32'(done_o),      32'(m_phase == 2));
      check("mode",  32'(mode_o),      32'(m_mode));
      check("max",   32'(max_cnt_o),   32'(m_max));
      if (m_phase == 1) begin
        check("idx", 32'(bin_idx_o), 32'(m_idx));
        check("cnt", 32'(bin_cnt_o), 32'(m_snap[m_idx]));
      end
    end
  end

  function automatic logic [N-1:0][P-1:0] pack(input int v [N]);
    logic [N-1:0][P-1:0] r;
    for (int i = 0; i < N; i++) r[i] = P'(v[i]);
    return r;
  endfunction

  // Runs one scan starting now (just after a rising edge); returns the cycle of
  // the first done pulse (0 if none) and the number of done pulses seen.
  task automatic scan(input logic [N-1:0][P-1:0] cnt, input int stall_lo, input int stall_hi,
                      input int change_at, input int restart_at, input int reset_at,
                      output int done_n, output int done_cnt);
    done_n = 0; done_cnt = 0;
    interval_cnt_i = cnt;
    start_i = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      start_i = (n == restart_at);
      if (n == change_at) for (int i = 0; i < N; i++) interval_cnt_i[i] = P'(200);
      bin_ready_i = !(n >= stall_lo && n <= stall_hi);
      if (done_o) begin
        done_cnt++;
        if (done_n == 0) done_n = n;
      end
      if (n == reset_at) begin
        rst_n = 1'b0; #1;
        check("rst_busy",  32'(busy_o),      0);
        check("rst_valid", 32'(bin_valid_o), 0);
        check("rst_done",  32'(done_o),      0);
        check("rst_idx",   32'(bin_idx_o),   0);
        check("rst_cnt",   32'(bin_cnt_o),   0);
        check("rst_mode",  32'(mode_o),      0);
        check("rst_max",   32'(max_cnt_o),   0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        break;
      end
      if (done_n != 0 && n > done_n + 3) break;
    end
    start_i = 1'b0;
    bin_ready_i = 1'b1;
  endtask

  int dn, dc;
  int v_a [N] = '{3, 9, 1, 0, 9, 2, 5, 4};
  int v_z [N] = '{0, 0, 0, 0, 0, 0, 0, 0};
  int v_b [N] = '{1, 2, 3, 4, 5, 6, 7, 255};
  int v_c [N] = '{10, 20, 30, 40, 50, 60, 70, 80};

  initial begin
    bin_ready_i = 1'b1;
    #12;
    check("init_busy",  32'(busy_o),      0);
    check("init_valid", 32'(bin_valid_o), 0);
    check("init_mode",  32'(mode_o),      0);
    check("init_max",   32'(max_cnt_o),   0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Tie between bins 1 and 4 resolves to bin 1; minimum latency.
    scan(pack(v_a), 0, 0, 0, 0, 0, dn, dc);
    check("a_done_cyc", 32'(dn), 9);
    check("a_done_cnt", 32'(dc), 1);
    check("a_mode", 32'(mode_o), 32'h02);
    check("a_max",  32'(max_cnt_o), 9);

    // All-zero histogram.
    scan(pack(v_z), 0, 0, 0, 0, 0, dn, dc);
    check("z_done_cyc", 32'(dn), 9);
    check("z_mode", 32'(mode_o), 0);
    check("z_max",  32'(max_cnt_o), 0);

    // Backpressure: three stall cycles on bin 2.
    scan(pack(v_b), 3, 5, 0, 0, 0, dn, dc);
    check("b_done_cyc", 32'(dn), 12);
    check("b_mode", 32'(mode_o), 32'h80);
    check("b_max",  32'(max_cnt_o), 255);

    // Inputs change after the snapshot.
    scan(pack(v_c), 0, 0, 1, 0, 0, dn, dc);
    check("c_done_cyc", 32'(dn), 9);
    check("c_mode", 32'(mode_o), 32'h80);
    check("c_max",  32'(max_cnt_o), 80);

    // Second start mid-scan is ignored.
    scan(pack(v_a), 0, 0, 0, 3, 0, dn, dc);
    check("r_done_cyc", 32'(dn), 9);
    check("r_done_cnt", 32'(dc), 1);
    check("r_mode", 32'(mode_o), 32'h02);

    // Reset mid-scan, then a normal scan.
    scan(pack(v_b), 0, 0, 0, 0, 4, dn, dc);
    check("x_done_cnt", 32'(dc), 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("x_quiet_done", 32'(done_o), 0);
      check("x_quiet_mode", 32'(mode_o), 0);
    end
    scan(pack(v_a), 0, 0, 0, 0, 0, dn, dc);
    check("y_done_cyc", 32'(dn), 9);
    check("y_mode", 32'(mode_o), 32'h02);
    check("y_max",  32'(max_cnt_o), 9);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interval_hist_reader.md
INTERVAL_HIST_READER -- requirements
Module: interval_hist_reader

Interface
REQ-001 Parameter interval_size, default 8, number of interval bins; bin width of the one-hot mode vector.
REQ-002 Parameter para, default 8, bit width of each bin counter and of the count outputs.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start_i  input  1  one-cycle pulse: histogram accumulation finished, snapshot and read out.
REQ-006 interval_cnt_i  input  [interval_size][para]  per-bin occurrence counters from the accumulating stage.
REQ-007 busy_o  output  1  high from the accepted start until done_o, inclusive.
REQ-008 bin_valid_o  output  1  a bin record is presented.
REQ-009 bin_ready_i  input  1  downstream accepts the bin record.
REQ-010 bin_idx_o  output  $clog2(interval_size)  index of the presented bin.
REQ-011 bin_cnt_o  output  para  snapshot count of the presented bin.
REQ-012 mode_o  output  interval_size  one-hot argmax bin; all-zero when every count is zero.
REQ-013 max_cnt_o  output  para  count of the argmax bin.
REQ-014 done_o  output  1  one-cycle pulse: scan complete, mode_o/max_cnt_o valid.

Function
REQ-015 FSM states IDLE, SCAN, DONE; IDLE->SCAN on start_i; SCAN->DONE on handshake of bin interval_size-1; DONE->IDLE unconditionally after one cycle.
REQ-016 On start_i in IDLE, interval_cnt_i captured into an internal snapshot at that edge; later input changes do not affect the scan.
REQ-017 start_i in SCAN or DONE ignored; no snapshot, no restart.
REQ-018 In SCAN, bin_valid_o high every cycle; bin_idx_o starts at 0 and increments by 1 per handshake (bin_valid_o & bin_ready_i).
REQ-019 bin_idx_o/bin_cnt_o held stable while bin_valid_o high and bin_ready_i low.
REQ-020 Running max updated on each handshake: bin replaces the max only if its count is strictly greater; ties keep the lowest index.
REQ-021 Running max initialised to count 0 / mode all-zero at snapshot; all-zero histogram yields mode_o=0, max_cnt_o=0.
REQ-022 Minimum latency: start_i at cycle 0 -> bins presented cycles 1..interval_size -> done_o at cycle interval_size+1 with bin_ready_i held high.
REQ-023 mode_o/max_cnt_o updated only in DONE; held until the next DONE.
REQ-024 busy_o low and bin_valid_o low in IDLE; done_o high only in DONE.
REQ-025 Counts compared unsigned at para bits; no arithmetic on counts, no saturation needed.

Reset
REQ-026 rst_n low: FSM->IDLE, bin_valid_o=0, busy_o=0, done_o=0, bin_idx_o=0, bin_cnt_o=0, mode_o=0, max_cnt_o=0, snapshot cleared, asynchronously.
REQ-027 Reset during SCAN abandons the scan; no done_o, previous mode_o/max_cnt_o lost (zeroed).
REQ-028 First start_i accepted on the first rising edge after rst_n deasserts.

Structure
REQ-029 interval_size, para and the FSM state enum live in the shared pipeline package used by the pipe stages.
REQ-030 Single module; no sub-module required. The argmax comparator is inline.

Verification
REQ-031 counts {3,9,1,0,9,2,5,4} (bin0..7), bin_ready_i=1, start pulse -> bins 0..7 cycles 1..8 with those counts, done_o cycle 9, mode_o=8'b00000010, max_cnt_o=9.
REQ-032 all counts 0, start -> eight bins with cnt 0, done_o, mode_o=0, max_cnt_o=0.
REQ-033 counts {1,2,3,4,5,6,7,255}, bin_ready_i low for 3 cycles on bin 2 -> bin 2 held stable, done_o at cycle 12, mode_o=8'b10000000, max_cnt_o=255.
REQ-034 interval_cnt_i changed to all 200 one cycle after start -> bin stream and result reflect original snapshot only.
REQ-035 second start_i during SCAN -> ignored, single done_o; rst_n pulsed low mid-scan -> outputs zero immediately, no done_o, next start accepted normally.
